// File: rtl/hdlc_tx_channel.sv
// HDLC transmit channel: pulls bytes from the Tx buffer and serialises them LSB-first
// between 0x7E flags with zero insertion, abort generation and a forced inter-frame gap.
module hdlc_tx_channel #(
  parameter int IFG_CYCLES = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_DataValid,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_LastByte,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Done
);

  localparam logic [7:0] FLAG = 8'h7E;
  localparam int IFGW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_OPEN, S_DATA, S_CLOSE, S_ABORT, S_IFG
  } state_t;

  state_t          state_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            last_q;
  logic [2:0]      ones_q;
  logic [IFGW-1:0] ifg_q;
  logic            tx_q;
  logic            valid_q;
  logic            aborted_q;
  logic            done_q;

  logic       in_frame;
  logic       abort_req;
  logic       unit_end;
  logic       fetch_slot;
  logic [2:0] bit_nx;
  logic       data_nx;

  always_comb begin
    in_frame   = (state_q == S_OPEN) || (state_q == S_DATA) || (state_q == S_CLOSE);
    abort_req  = in_frame && (Tx_AbortFrame || !Tx_Enable);
    // A byte ends after bit 7, or after the stuffed zero that follows it.
    unit_end   = (state_q == S_DATA) && (bit_q == 3'd7) && (ones_q != 3'd5);
    fetch_slot = ((state_q == S_OPEN) && (bit_q == 3'd7)) || (unit_end && !last_q);
    bit_nx     = bit_q + 3'd1;
    data_nx    = shreg_q[bit_nx];
  end

  assign Tx_RdBuff       = fetch_slot && Tx_DataValid && !abort_req;
  assign Tx              = tx_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx_Done         = done_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      bit_q     <= 3'd0;
      shreg_q   <= 8'd0;
      last_q    <= 1'b0;
      ones_q    <= 3'd0;
      ifg_q     <= '0;
      tx_q      <= 1'b1;
      valid_q   <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q    <= 1'b1;
          valid_q <= 1'b0;
          if (Tx_Enable && Tx_DataValid) begin
            state_q <= S_OPEN;
            bit_q   <= 3'd0;
            ones_q  <= 3'd0;
            tx_q    <= FLAG[0];
            valid_q <= 1'b1;
          end
        end
        S_OPEN, S_DATA, S_CLOSE: begin
          // Abort and underrun both take priority over any frame progress.
          if (abort_req || (fetch_slot && !Tx_DataValid)) begin
            state_q   <= S_ABORT;
            bit_q     <= 3'd0;
            ones_q    <= 3'd0;
            tx_q      <= 1'b0;
            valid_q   <= 1'b0;
            aborted_q <= 1'b1;
          end else if (fetch_slot) begin
            state_q <= S_DATA;
            shreg_q <= Tx_Data;
            last_q  <= Tx_LastByte;
            bit_q   <= 3'd0;
            tx_q    <= Tx_Data[0];
            ones_q  <= Tx_Data[0] ? ones_q + 3'd1 : 3'd0;
            valid_q <= 1'b1;
          end else if (state_q == S_DATA) begin
            if (ones_q == 3'd5) begin
              tx_q   <= 1'b0;
              ones_q <= 3'd0;
            end else if (!unit_end) begin
              bit_q  <= bit_nx;
              tx_q   <= data_nx;
              ones_q <= data_nx ? ones_q + 3'd1 : 3'd0;
            end else begin
              state_q <= S_CLOSE;
              bit_q   <= 3'd0;
              ones_q  <= 3'd0;
              tx_q    <= FLAG[0];
            end
          end else if (bit_q != 3'd7) begin
            bit_q <= bit_nx;
            tx_q  <= FLAG[bit_nx];
          end else begin
            state_q <= S_IFG;
            ifg_q   <= '0;
            tx_q    <= 1'b1;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_ABORT: begin
          tx_q    <= 1'b1;
          valid_q <= 1'b0;
          if (bit_q != 3'd7) begin
            bit_q <= bit_nx;
          end else begin
            state_q <= S_IFG;
            ifg_q   <= '0;
          end
        end
        S_IFG: begin
          tx_q    <= 1'b1;
          valid_q <= 1'b0;
          if (ifg_q == IFGW'(IFG_CYCLES - 1)) begin
            state_q <= S_IDLE;
          end else begin
            ifg_q <= ifg_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_tx_channel.sv
// Directed bench for hdlc_tx_channel: each frame is logged cycle by cycle and the
// logged line pattern is compared with hand-derived sequences.
module tb_hdlc_tx_channel;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Tx_Enable;
  logic       Tx_DataValid;
  logic [7:0] Tx_Data;
  logic       Tx_LastByte;
  logic       Tx_AbortFrame;
  logic       Tx_RdBuff;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_AbortedTrans;
  logic       Tx_Done;

  int tests_run = 0;
  int tests_failed = 0;

  logic tx_log [0:63];
  logic rd_log [0:63];
  logic vf_log [0:63];
  logic ab_log [0:63];
  logic dn_log [0:63];

  always #5 Clk = ~Clk;

  hdlc_tx_channel #(.IFG_CYCLES(8)) dut (
    .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_DataValid(Tx_DataValid),
    .Tx_Data(Tx_Data), .Tx_LastByte(Tx_LastByte), .Tx_AbortFrame(Tx_AbortFrame),
    .Tx_RdBuff(Tx_RdBuff), .Tx(Tx), .Tx_ValidFrame(Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done)
  );

  // Cycle 0 presents the first byte; the buffer advances on each sampled Tx_RdBuff.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int nbytes,
                           input int navail, input int ncyc, input int abort_cyc,
                           input int rst_cyc);
    int idx = 0;
    for (int c = 0; c < 64; c++) begin
      tx_log[c] = 1'b1; rd_log[c] = 1'b0; vf_log[c] = 1'b0; ab_log[c] = 1'b0; dn_log[c] = 1'b0;
    end
    for (int c = 0; c < ncyc; c++) begin
      Tx_Enable     = 1'b1;
      Tx_AbortFrame = (c == abort_cyc);
      Rst           = (c == rst_cyc);
      Tx_DataValid  = (idx < navail);
      Tx_Data       = (idx == 0) ? b0 : b1;
      Tx_LastByte   = (idx == nbytes - 1);
      @(negedge Clk);
      tx_log[c] = Tx; rd_log[c] = Tx_RdBuff; vf_log[c] = Tx_ValidFrame;
      ab_log[c] = Tx_AbortedTrans; dn_log[c] = Tx_Done;
      if (Tx_RdBuff) idx++;
      @(posedge Clk);
      #1;
    end
    Tx_DataValid = 1'b0; Tx_AbortFrame = 1'b0; Rst = 1'b0; Tx_LastByte = 1'b0;
  endtask

  // sel: 0 Tx, 1 RdBuff, 2 ValidFrame, 3 AbortedTrans, 4 Done
  function automatic string seq(input int sel, input int a, input int b);
    string s = "";
    logic v;
    for (int i = a; i <= b; i++) begin
      case (sel)
        0: v = tx_log[i];
        1: v = rd_log[i];
        2: v = vf_log[i];
        3: v = ab_log[i];
        default: v = dn_log[i];
      endcase
      s = {s, (v === 1'b1) ? "1" : (v === 1'b0) ? "0" : "x"};
    end
    return s;
  endfunction

  function automatic int count(input int sel, input int a, input int b);
    string s = seq(sel, a, b);
    int n = 0;
    for (int i = 0; i < s.len(); i++) if (s.getc(i) == "1") n++;
    return n;
  endfunction

  task automatic test_reset;
    Rst = 1'b1; Tx_Enable = 1'b1; Tx_DataValid = 1'b0; Tx_Data = 8'h00;
    Tx_LastByte = 1'b0; Tx_AbortFrame = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    tests_run++;
    if ({Tx, Tx_ValidFrame, Tx_RdBuff, Tx_AbortedTrans, Tx_Done} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b, want 10000",
               {Tx, Tx_ValidFrame, Tx_RdBuff, Tx_AbortedTrans, Tx_Done});
    end
    @(posedge Clk); #1;
    Rst = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_zero;
    string got;
    run_frame(8'h00, 8'h00, 1, 1, 36, -1, -1);
    got = seq(0, 1, 32); tests_run++;
    if (got != "01111110000000000111111011111111") begin
      tests_failed++; $display("FAIL zero_tx: got %s, want 01111110000000000111111011111111", got);
    end
    tests_run++;
    if (count(1, 0, 35) != 1 || rd_log[8] !== 1'b1) begin
      tests_failed++; $display("FAIL zero_rdbuff: got %s, want pulse at cycle 8", seq(1, 0, 35));
    end
    got = seq(2, 0, 26); tests_run++;
    if (got != "011111111111111111111111100") begin
      tests_failed++; $display("FAIL zero_valid: got %s, want 011111111111111111111111100", got);
    end
    tests_run++;
    if (count(4, 0, 35) != 1 || dn_log[25] !== 1'b1) begin
      tests_failed++; $display("FAIL zero_done: got %s, want pulse at cycle 25", seq(4, 0, 35));
    end
    $display("[TB] test_single_zero done");
  endtask

  task automatic test_stuff_ff;
    string got;
    run_frame(8'hFF, 8'h00, 1, 1, 40, -1, -1);
    got = seq(0, 9, 25); tests_run++;
    if (got != "11111011101111110") begin
      tests_failed++; $display("FAIL ff_tx: got %s, want 11111011101111110", got);
    end
    tests_run++;
    if (count(4, 0, 39) != 1 || dn_log[26] !== 1'b1) begin
      tests_failed++; $display("FAIL ff_done: got %s, want pulse at cycle 26", seq(4, 0, 39));
    end
    $display("[TB] test_stuff_ff done");
  endtask

  task automatic test_back_to_back;
    string got;
    run_frame(8'hF0, 8'h01, 2, 2, 44, -1, -1);
    got = seq(0, 9, 33); tests_run++;
    if (got != "0000111110000000001111110") begin
      tests_failed++; $display("FAIL b2b_tx: got %s, want 0000111110000000001111110", got);
    end
    tests_run++;
    if (count(1, 0, 43) != 2 || rd_log[8] !== 1'b1 || rd_log[16] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_rdbuff: got %s, want pulses at 8 and 16", seq(1, 0, 43));
    end
    tests_run++;
    if (count(4, 0, 43) != 1 || dn_log[34] !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_done: got %s, want pulse at cycle 34", seq(4, 0, 43));
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_abort;
    string got;
    run_frame(8'h55, 8'h00, 1, 1, 32, 12, -1);
    got = seq(0, 13, 28); tests_run++;
    if (got != "0111111111111111") begin
      tests_failed++; $display("FAIL abort_tx: got %s, want 0111111111111111", got);
    end
    tests_run++;
    if (count(3, 0, 31) != 1 || ab_log[13] !== 1'b1) begin
      tests_failed++; $display("FAIL abort_pulse: got %s, want pulse at cycle 13", seq(3, 0, 31));
    end
    got = seq(2, 11, 14); tests_run++;
    if (got != "1100") begin
      tests_failed++; $display("FAIL abort_valid: got %s, want 1100", got);
    end
    tests_run++;
    if (count(4, 0, 31) != 0) begin
      tests_failed++; $display("FAIL abort_no_done: got %s, want no pulse", seq(4, 0, 31));
    end
    $display("[TB] test_abort done");
  endtask

  task automatic test_underrun;
    string got;
    run_frame(8'h00, 8'hA5, 2, 1, 36, -1, -1);
    tests_run++;
    if (count(1, 0, 35) != 1 || rd_log[8] !== 1'b1) begin
      tests_failed++; $display("FAIL underrun_rdbuff: got %s, want single pulse at 8", seq(1, 0, 35));
    end
    got = seq(0, 9, 32); tests_run++;
    if (got != "000000000111111111111111") begin
      tests_failed++; $display("FAIL underrun_tx: got %s, want 000000000111111111111111", got);
    end
    tests_run++;
    if (count(3, 0, 35) != 1 || ab_log[17] !== 1'b1 || count(4, 0, 35) != 0) begin
      tests_failed++; $display("FAIL underrun_pulses: aborted %s done %s, want abort at 17 only",
                               seq(3, 0, 35), seq(4, 0, 35));
    end
    $display("[TB] test_underrun done");
  endtask

  task automatic test_abort_idle;
    string got;
    run_frame(8'h00, 8'h00, 1, 0, 6, 2, -1);
    got = {seq(0, 0, 5), seq(2, 0, 5), seq(3, 0, 5)}; tests_run++;
    if (got != "111111000000000000") begin
      tests_failed++; $display("FAIL idle_abort: got %s, want 111111000000000000", got);
    end
    $display("[TB] test_abort_idle done");
  endtask

  task automatic test_reset_midframe;
    string got;
    run_frame(8'h00, 8'h00, 1, 1, 26, -1, 20);
    got = {seq(0, 21, 25), seq(2, 21, 25)}; tests_run++;
    if (got != "1111100000") begin
      tests_failed++; $display("FAIL rst_mid_lines: got %s, want 1111100000", got);
    end
    tests_run++;
    if (count(3, 0, 25) != 0 || count(4, 0, 25) != 0 || count(1, 21, 25) != 0) begin
      tests_failed++; $display("FAIL rst_mid_pulses: aborted %s done %s, want none",
                               seq(3, 0, 25), seq(4, 0, 25));
    end
    run_frame(8'h00, 8'h00, 1, 1, 36, -1, -1);
    got = seq(0, 1, 24); tests_run++;
    if (got != "011111100000000001111110") begin
      tests_failed++; $display("FAIL rst_restart_tx: got %s, want 011111100000000001111110", got);
    end
    tests_run++;
    if (dn_log[25] !== 1'b1) begin
      tests_failed++; $display("FAIL rst_restart_done: got %s, want pulse at 25", seq(4, 0, 35));
    end
    $display("[TB] test_reset_midframe done");
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_stuff_ff();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_abort_idle();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hdlc_tx_channel.md
# hdlc_tx_channel

Serial HDLC transmit channel: the transmitting counterpart of the Rx channel checked by the bench assertions. Takes bytes from the Tx buffer through a read handshake and serialises them LSB-first at one bit per `Clk`. Frames are wrapped in opening and closing 0x7E flags, with zero insertion after five consecutive data 1s. Generates the abort pattern on request or on buffer underrun, and drives idle (all-ones) between frames. Sits between the Tx buffer and the `Tx` line.

## Interface
- `IFG_CYCLES`, default 8: number of idle 1-bits forced after every closing flag or abort pattern before a new frame may start (≥1).

- `Clk`  in  1  system clock
- `Rst`  in  1  synchronous reset, active-high
- `Tx_Enable`  in  1  channel enable; low holds/forces idle
- `Tx_DataValid`  in  1  buffer has a byte on `Tx_Data`
- `Tx_Data`  in  8  next byte; FCS bytes are supplied upstream as ordinary data
- `Tx_LastByte`  in  1  qualifies `Tx_Data` as the final byte of the frame
- `Tx_AbortFrame`  in  1  one-cycle abort request
- `Tx_RdBuff`  out  1  one-cycle pulse; byte on `Tx_Data`/`Tx_LastByte` captured at the end of this cycle
- `Tx`  out  1  serial line (registered)
- `Tx_ValidFrame`  out  1  high while flag or data bits of a frame are on `Tx`
- `Tx_AbortedTrans`  out  1  one-cycle pulse on the first abort-pattern bit
- `Tx_Done`  out  1  one-cycle pulse on the first cycle after the last closing-flag bit

## Operation
- States: IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT, IFG.
- IDLE:
  - `Tx`=1.
  - When `Tx_Enable && Tx_DataValid`, go to OPEN_FLAG.
- OPEN_FLAG / CLOSE_FLAG:
  - Send 0x7E LSB-first, i.e. 0,1,1,1,1,1,1,0 over 8 cycles.
  - Flag bits are never stuffed.
  - The ones-counter is cleared.
- Byte fetch:
  - `Tx_RdBuff` is asserted in the last `Tx` cycle of the current unit (final opening-flag bit, or final bit of a byte including any trailing stuffed zero).
  - This applies only if the previous byte was not last.
  - If `Tx_DataValid`=0 at that point: no `Tx_RdBuff`; go to ABORT (underrun).
- DATA:
  - Shift the byte out LSB-first.
  - A 3-bit ones-counter counts consecutive data 1s and persists across byte boundaries.
  - When it reaches 5, the next `Tx` cycle is an inserted 0 and the counter clears.
  - A data 0 clears the counter.
  - After the last bit (plus stuffed zero, if any) of a byte flagged `Tx_LastByte`, go to CLOSE_FLAG.
- ABORT:
  - Entered on `Tx_AbortFrame`, on `Tx_Enable` falling, or on underrun, from OPEN_FLAG/DATA/CLOSE_FLAG.
  - Sends 0,1,1,1,1,1,1,1 over 8 cycles, then goes to IFG.
  - `Tx_AbortFrame` in IDLE/IFG/ABORT is ignored.
- IFG:
  - `Tx`=1 for `IFG_CYCLES` cycles, then IDLE.
  - `Tx_Done` pulses on the first IFG cycle after CLOSE_FLAG only, never after ABORT.
- Simultaneous events:
  - Abort beats last-byte completion.
  - Abort sampled in the final CLOSE_FLAG cycle still aborts: no `Tx_Done`.
- Reset (also mid-frame):
  - `Tx`=1, `Tx_ValidFrame`=0, `Tx_RdBuff`=0, `Tx_AbortedTrans`=0, `Tx_Done`=0, state IDLE, counters 0.
  - No abort pattern is sent.

## Timing
- Cycle 0 = the cycle in which IDLE samples the start condition.
- Opening flag on `Tx` in cycles 1–8; `Tx_ValidFrame` rises in cycle 1.
- First `Tx_RdBuff` in cycle 8; first data bit in cycle 9.
- Abort/`Tx_Enable`-low sampled in cycle n: first abort bit and the `Tx_AbortedTrans` pulse in cycle n+1; `Tx_ValidFrame`=0 from n+1.
- `Tx_ValidFrame` falls in the cycle after the last closing-flag bit, the same cycle as `Tx_Done`.
- Earliest next start condition: the first IDLE cycle after IFG.

## Test plan
- Single byte 0x00, last:
  - `Tx` in cycles 1–24 = 0,1111110, 00000000, 0,1111110.
  - `Tx_RdBuff` only in cycle 8.
  - `Tx_Done` and `Tx_ValidFrame` fall in cycle 25.
  - `Tx`=1 in cycles 25–32.
- Byte 0xFF, last: data cycles 9–17 = 1,1,1,1,1,0,1,1,1; closing flag in cycles 18–25; `Tx_Done` in cycle 26.
- Bytes 0xF0, 0x01 (last):
  - Stuffed 0 inserted after bit 0 of the second byte (ones run spans the boundary).
  - Second `Tx_RdBuff` in cycle 16; 17 data cycles total.
- Abort sampled during data bit 3:
  - Next 8 cycles `Tx` = 0,1111111.
  - `Tx_AbortedTrans` is a 1-cycle pulse and `Tx_ValidFrame` goes 0.
  - Then 8 idle 1s; no `Tx_Done`.
- Two-byte frame with `Tx_DataValid`=0 when the second byte is due: no second `Tx_RdBuff`; abort pattern plus `Tx_AbortedTrans`.
- `Rst` pulsed in the middle of the closing flag: `Tx`=1 and all pulses 0 from the next cycle; no abort pattern; a new frame starts normally afterwards.
